gate_identifier: RTL and testbench
==================================

Name: gate_identifier

Overview:
- Sequential characteriser for the team's 2-input logic gates; the inverse of a gate.
- A gate maps inputs to an output. This block drives all four input vectors into an attached gate instance, samples its output, builds the truth table and classifies it as AND/OR/NOT/NAND/NOR/XOR/XNOR or unknown.
- Used in self-test wrappers and in gate-library regression.

Parameters:
- SETTLE_CYCLES, 2, cycles drive_a/drive_b are held before sampling begins; legal range 1..15.
- SAMPLES, 2, consecutive cycles sense_y is sampled per vector; legal range 1..15. All samples must agree.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin characterisation; accepted only in IDLE
- drive_a  output  1  stimulus to gate input a
- drive_b  output  1  stimulus to gate input b
- sense_y  input  1  gate output under test
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when results update
- truth_table  output  4  bit index {a,b}; bit k = sampled y for vector k
- gate_code  output  3  classification; see package constants
- unstable  output  1  some vector saw disagreeing samples

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high: ports clk and rst; rst sampled on the rising clk edge.
- Reset values:
  - busy=0, done=0, drive_a=0, drive_b=0.
  - truth_table=0, gate_code=UNKNOWN (7), unstable=0.
  - FSM=IDLE, all counters 0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - drive_a=drive_b=0; busy=0.
  - Results hold their last values.
  - start=1 at an edge: go to SETTLE, vector=0, busy=1, clear the sample accumulators.
- SETTLE:
  - drive_{a,b}={vector[1],vector[0]}.
  - Hold for SETTLE_CYCLES edges, then go to SAMPLE.
- SAMPLE:
  - Capture sense_y on each of SAMPLES consecutive edges.
  - First sample sets tt_work[vector]. Any later sample differing from the first sets unstable_work.
  - On the last sample edge: if vector<3, vector++ and go to SETTLE; otherwise go to DONE.
- DONE (one cycle):
  - done=1, busy=0, drives return to 0.
  - truth_table<=tt_work, unstable<=unstable_work, gate_code<=classify(tt_work, unstable_work).
  - Next state is IDLE.
- Latency: done asserts exactly 4*(SETTLE_CYCLES+SAMPLES)+1 cycles after the start edge. Defaults give 17.
- Classification, with truth_table written as bits [3:0]:
  - AND=1000, OR=1110, NOT(a)=0011, NAND=0111, NOR=0001, XOR=0110, XNOR=1001.
  - Any other pattern, or unstable=1, gives UNKNOWN.
- start while busy or in DONE: ignored, no queueing.
- start held high continuously: a new sweep begins in the first IDLE cycle after DONE.
- rst mid-sweep: immediate return to reset values. Partial results are discarded and done is not pulsed.
- sense_y is assumed synchronous to clk. The block does no synchronisation.
- Counters are sized to hold 15. Out-of-range parameters are flagged by a simulation-time elaboration check.

Decomposition:
- Package gate_id_pkg holds:
  - gate_code constants: AND=0, OR=1, NOT=2, NAND=3, NOR=4, XOR=5, XNOR=6, UNKNOWN=7.
  - The seven 4-bit truth-table constants.
  - The FSM state enum.
- Sub-module gate_classifier: purely combinational, truth table + unstable in, gate_code out. Unit-testable in isolation.
- FSM, counters and accumulators stay in gate_identifier.

Test Plan:
- Reset, then start with sense_y driven from an XOR of drive_a/drive_b (default params) -> done at cycle 17 after start; truth_table=0110, gate_code=5, unstable=0.
- Loop over all seven gate types, one sweep each -> gate_code 0..6 respectively; truth_tables 1000, 1110, 0011, 0111, 0001, 0110, 1001.
- sense_y stuck at 1 -> truth_table=1111, gate_code=7, unstable=0.
- SAMPLES=3 with AND gate, sense_y toggled during the second sample of vector 3 -> unstable=1, gate_code=7.
- rst asserted at cycle 8 of a sweep, then start re-issued -> all outputs at reset values after the rst edge, no done pulse. Fresh sweep completes normally with correct code.
- start pulsed at cycles 3 and 10 of a sweep -> ignored; exactly one done pulse; drive_a/drive_b sequence 00,01,10,11 each held SETTLE_CYCLES+SAMPLES cycles.

Source files
------------

// File: rtl/gate_identifier_pkg.sv
// Shared constants and types for the 2-input gate characteriser.
package gate_id_pkg;

    // Classification codes reported on gate_code
    localparam logic [2:0] GC_AND     = 3'd0;
    localparam logic [2:0] GC_OR      = 3'd1;
    localparam logic [2:0] GC_NOT     = 3'd2;
    localparam logic [2:0] GC_NAND    = 3'd3;
    localparam logic [2:0] GC_NOR     = 3'd4;
    localparam logic [2:0] GC_XOR     = 3'd5;
    localparam logic [2:0] GC_XNOR    = 3'd6;
    localparam logic [2:0] GC_UNKNOWN = 3'd7;

    // Reference truth tables, bit index {a,b}
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOT  = 4'b0011;  // NOT(a), b ignored
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    // Settle/sample counters hold up to 15
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/gate_identifier_if.sv
// Control, stimulus and result signals between the characteriser and its user.
interface gate_identifier_if;
    logic       start;
    logic       drive_a;
    logic       drive_b;
    logic       sense_y;
    logic       busy;
    logic       done;
    logic [3:0] truth_table;
    logic [2:0] gate_code;
    logic       unstable;

    // User side: issues start and closes the loop through the gate under test
    modport master (
        output start, sense_y,
        input  drive_a, drive_b, busy, done, truth_table, gate_code, unstable
    );

    // Characteriser side
    modport slave (
        input  start, sense_y,
        output drive_a, drive_b, busy, done, truth_table, gate_code, unstable
    );
endinterface

// File: rtl/gate_identifier_classifier.sv
// Combinational truth-table matcher; any instability forces UNKNOWN.
module gate_classifier
    import gate_id_pkg::*;
(
    input  logic [3:0] tt_i,
    input  logic       unstable_i,
    output logic [2:0] gate_code_o
);

    // Match the sampled table against the known gate library
    always_comb begin
        gate_code_o = GC_UNKNOWN;
        if (!unstable_i) begin
            case (tt_i)
                TT_AND:  gate_code_o = GC_AND;
                TT_OR:   gate_code_o = GC_OR;
                TT_NOT:  gate_code_o = GC_NOT;
                TT_NAND: gate_code_o = GC_NAND;
                TT_NOR:  gate_code_o = GC_NOR;
                TT_XOR:  gate_code_o = GC_XOR;
                TT_XNOR: gate_code_o = GC_XNOR;
                default: gate_code_o = GC_UNKNOWN;
            endcase
        end
    end

endmodule

// File: rtl/gate_identifier.sv
// Sweeps all four input vectors through an attached gate, samples its output
// and reports the resulting truth table and gate classification.
module gate_identifier
    import gate_id_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int SAMPLES       = 2
) (
    input logic         clk,
    input logic         rst,
    gate_identifier_if.slave bus
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("gate_identifier: SETTLE_CYCLES out of range 1..15");
    end
    if (SAMPLES < 1 || SAMPLES > 15) begin : g_bad_samples
        $error("gate_identifier: SAMPLES out of range 1..15");
    end

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       vec_q, vec_d;

    logic [3:0]       tt_work_q;
    logic             unst_work_q;
    logic [3:0]       tt_q;
    logic [2:0]       code_q;
    logic             unst_q;
    logic             done_q;
    logic [2:0]       code_w;
    logic             sweeping;

    gate_classifier u_cls (
        .tt_i        (tt_work_q),
        .unstable_i  (unst_work_q),
        .gate_code_o (code_w)
    );

    // State, phase counter and vector index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
        end
    end

    // Next state: settle then sample each vector in turn, then one DONE cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                    vec_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    cnt_d = '0;
                    if (vec_q == 2'd3) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d   = vec_q + 1'b1;
                        state_d = ST_SETTLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                vec_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sample accumulation during the sweep; results published from DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            tt_work_q   <= '0;
            unst_work_q <= 1'b0;
            tt_q        <= '0;
            code_q      <= GC_UNKNOWN;
            unst_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == ST_DONE);
            if (state_q == ST_IDLE && bus.start) begin
                tt_work_q   <= '0;
                unst_work_q <= 1'b0;
            end
            if (state_q == ST_SAMPLE) begin
                if (cnt_q == '0) begin
                    tt_work_q[vec_q] <= bus.sense_y;
                end else if (bus.sense_y != tt_work_q[vec_q]) begin
                    unst_work_q <= 1'b1;
                end
            end
            if (state_q == ST_DONE) begin
                tt_q   <= tt_work_q;
                unst_q <= unst_work_q;
                code_q <= code_w;
            end
        end
    end

    assign sweeping        = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign bus.busy        = sweeping;
    assign bus.drive_a     = sweeping & vec_q[1];
    assign bus.drive_b     = sweeping & vec_q[0];
    assign bus.done        = done_q;
    assign bus.truth_table = tt_q;
    assign bus.gate_code   = code_q;
    assign bus.unstable    = unst_q;

endmodule

// File: tb/tb_gate_identifier.sv
// Bench for gate_identifier: directed steps plus randomized sweeps checked
// against a truth-table model built from boolean gate definitions.
module tb_gate_identifier;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gate_identifier_if bus ();
    gate_identifier_if bus2 ();

    gate_identifier #(.SETTLE_CYCLES(2), .SAMPLES(2)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave)
    );
    gate_identifier #(.SETTLE_CYCLES(2), .SAMPLES(3)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] tt_f  = 4'b0000;  // gate model attached to dut
    logic [3:0] tt_f2 = 4'b0000;  // gate model attached to dut2
    logic       glitch = 1'b0;

    // Attached gates: y looked up by {a,b}
    always_comb bus.sense_y  = tt_f[{bus.drive_a, bus.drive_b}];
    always_comb bus2.sense_y = tt_f2[{bus2.drive_a, bus2.drive_b}] ^ glitch;

    // Truth table of gate g, computed from its boolean definition
    function automatic logic [3:0] tt_of(input int g);
        logic [3:0] t;
        logic a, b, y;
        t = '0;
        for (int v = 0; v < 4; v++) begin
            a = v[1];
            b = v[0];
            case (g)
                0: y = a & b;
                1: y = a | b;
                2: y = ~a;
                3: y = ~(a & b);
                4: y = ~(a | b);
                5: y = a ^ b;
                6: y = ~(a ^ b);
                default: y = 1'b0;
            endcase
            t[v] = y;
        end
        return t;
    endfunction

    function automatic logic [2:0] classify(input logic [3:0] t, input logic u);
        if (u) return 3'd7;
        for (int g = 0; g < 7; g++)
            if (tt_of(g) == t) return 3'(g);
        return 3'd7;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, {7'd0, bus.busy}, 8'd0);
        chk({tag, "_done"}, {7'd0, bus.done}, 8'd0);
        chk({tag, "_drv"},  {6'd0, bus.drive_a, bus.drive_b}, 8'd0);
        chk({tag, "_tt"},   {4'd0, bus.truth_table}, 8'd0);
        chk({tag, "_code"}, {5'd0, bus.gate_code}, 8'd7);
        chk({tag, "_unst"}, {7'd0, bus.unstable}, 8'd0);
    endtask

    // One sweep on dut with default params (phase length 4, latency 17).
    // k counts edges after the start edge; p1/p2 inject extra start pulses.
    task automatic sweep(input logic [3:0] t, input bit hold, input int p1, input int p2);
        localparam int PH  = 4;
        localparam int LAT = 4 * PH + 1;
        logic [1:0] v;
        tt_f = t;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (k < 4 * PH) begin
                v = 2'(k / PH);
                chk("sw_busy", {7'd0, bus.busy}, 8'd1);
                chk("sw_drv",  {6'd0, bus.drive_a, bus.drive_b}, {6'd0, v});
                chk("sw_done", {7'd0, bus.done}, 8'd0);
            end else if (k == 4 * PH) begin
                chk("dn_busy", {7'd0, bus.busy}, 8'd0);
                chk("dn_drv",  {6'd0, bus.drive_a, bus.drive_b}, 8'd0);
                chk("dn_done", {7'd0, bus.done}, 8'd0);
            end else if (k == LAT) begin
                chk("res_done", {7'd0, bus.done}, 8'd1);
                chk("res_busy", {7'd0, bus.busy}, 8'd0);
                chk("res_tt",   {4'd0, bus.truth_table}, {4'd0, t});
                chk("res_code", {5'd0, bus.gate_code}, {5'd0, classify(t, 1'b0)});
                chk("res_unst", {7'd0, bus.unstable}, 8'd0);
            end else begin
                chk("post_done", {7'd0, bus.done}, 8'd0);
                chk("post_busy", {7'd0, bus.busy}, {7'd0, hold});
            end
            bus.start = hold || (k == p1) || (k == p2);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        logic [3:0] t;
        int g, dones;
        bus.start  = 1'b0;
        bus2.start = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        chk("rst2_code", {5'd0, bus2.gate_code}, 8'd7);
        rst = 1'b0;

        // XOR, then every library gate, with the first sweep carrying stray starts
        sweep(tt_of(5), 1'b0, 3, 10);
        for (int i = 0; i < 7; i++) sweep(tt_of(i), 1'b0, -1, -1);

        // Output stuck at 1
        sweep(4'b1111, 1'b0, -1, -1);

        // Start held high: a new sweep begins right after DONE, then reset
        sweep(tt_of(1), 1'b1, -1, -1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a sweep
        sweep(tt_of(0), 1'b0, -1, -1);
        tt_f = tt_of(5);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("midrst_nodone", 8'(dones), 8'd0);
        sweep(tt_of(3), 1'b0, -1, -1);

        // SAMPLES=3, AND gate, glitch on the second sample of vector 3
        tt_f2 = tt_of(0);
        @(negedge clk);
        bus2.start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 22; k++) begin
            @(negedge clk);
            bus2.start = 1'b0;
            if (k == 21) begin
                chk("un_done", {7'd0, bus2.done}, 8'd1);
                chk("un_unst", {7'd0, bus2.unstable}, 8'd1);
                chk("un_code", {5'd0, bus2.gate_code}, 8'd7);
                chk("un_tt",   {4'd0, bus2.truth_table}, {4'd0, tt_of(0)});
            end else begin
                chk("un_nodone", {7'd0, bus2.done}, 8'd0);
            end
            glitch = (k == 18);
        end
        glitch = 1'b0;

        // Randomized sweeps: library gates and arbitrary functions
        for (int i = 0; i < 12; i++) begin
            g = $urandom_range(0, 8);
            t = (g < 7) ? tt_of(g) : 4'($urandom_range(0, 15));
            sweep(t, 1'b0, $urandom_range(1, 15), $urandom_range(1, 15));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
